// File: rtl/det_pkg.sv
// Shared definitions for the ones-count detector scheduler.
// Holds the FSM state encoding, default sizing and the width helper.
package det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam int DEF_N_CH      = 4;
    localparam int DEF_MATCH_LEN = 5;

    // Bits needed to encode 0..value-1, never less than one.
    function automatic int width_of(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/det_rr_arb.sv
// Round-robin arbiter: the search starts at the pointer and wraps upward.
// The grant is combinational; the pointer moves past the winner on each grant.
module det_rr_arb
    import det_pkg::*;
#(
    parameter  int N_CH = DEF_N_CH,
    localparam int CH_W = width_of(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] req,
    input  logic            enable,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] grant_idx
);

    logic [CH_W-1:0] ptr;
    logic            found;
    logic [CH_W-1:0] idx;

    // First requester at or above the pointer (with wrap) wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < N_CH; i++) begin
            int j;
            j = int'(ptr) + i;
            if (j >= N_CH) j = j - N_CH;
            idx = CH_W'(j);
            if (enable && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    // Pointer advances to the channel after the winner; holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/det_sched.sv
// Shared ones-count detector time-multiplexed over N_CH serial channels.
// Each channel keeps its own count; hits go out through a one-entry
// valid/ready buffer tagged with the channel number.
// Build option DET_SCHED_ZERO_CLR_EN: an accepted 0 clears the channel count
// (consecutive-ones mode); when undefined a 0 leaves the count untouched.
//
// Handshakes: a bit moves when in_valid[k] & in_ready[k]; a hit moves when
// hit_valid & hit_ready. hit_valid/hit_ch are held until that transfer, and
// grants are withheld while the buffer is full and not being drained, so a
// hit can never be overwritten.
module det_sched
    import det_pkg::*;
#(
    parameter  int N_CH      = DEF_N_CH,
    parameter  int MATCH_LEN = DEF_MATCH_LEN,
    localparam int CH_W      = width_of(N_CH),
    localparam int CNT_W     = width_of(MATCH_LEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N_CH-1:0] in_valid,
    input  logic [N_CH-1:0] in_data,
    output logic [N_CH-1:0] in_ready,
    input  logic [N_CH-1:0] ch_clr,
    output logic            hit_valid,
    output logic [CH_W-1:0] hit_ch,
    input  logic            hit_ready
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MATCH_LEN - 1);

    state_t          state;
    logic [CNT_W-1:0] cnt [N_CH];
    logic            grant_en;
    logic [N_CH-1:0] grant;
    logic [CH_W-1:0] grant_idx;
    logic            accept;
    logic            hit_load;

    // Grants only in RUN, with en high, and never into a blocked buffer.
    assign grant_en = (state == RUN) && en && !(hit_valid && !hit_ready);

    det_rr_arb #(.N_CH(N_CH)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .enable    (grant_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign in_ready = grant;
    assign accept   = |grant;
    // A clear on the granted channel swallows the bit, so it cannot hit.
    assign hit_load = accept && in_data[grant_idx] && (cnt[grant_idx] == LAST)
                      && !ch_clr[grant_idx];

    // Per-channel count contexts: clear wins over an accepted bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) cnt[k] <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (ch_clr[k]) begin
                    cnt[k] <= '0;
                end else if (grant[k]) begin
                    if (in_data[k]) begin
                        cnt[k] <= (cnt[k] == LAST) ? '0 : cnt[k] + 1'b1;
                    end else begin
`ifdef DET_SCHED_ZERO_CLR_EN
                        cnt[k] <= '0;
`else
                        cnt[k] <= cnt[k];
`endif
                    end
                end
            end
        end
    end

    // One-entry hit buffer: a new hit overrides a same-cycle drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_valid <= 1'b0;
            hit_ch    <= '0;
        end else if (hit_load) begin
            hit_valid <= 1'b1;
            hit_ch    <= grant_idx;
        end else if (hit_ready) begin
            hit_valid <= 1'b0;
        end
    end

    // Control FSM: IDLE until enabled, STALL while the consumer holds off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (en) state <= RUN;
                RUN: begin
                    if (!en)                          state <= IDLE;
                    else if (hit_valid && !hit_ready) state <= STALL;
                end
                STALL: begin
                    if (!en)            state <= IDLE;
                    else if (hit_ready) state <= RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
